// File: rtl/gb_cart_pkg.sv
// Shared cartridge-mapper definitions: RAM size codes, address-region
// decode constants, bank register widths and the ROM bank mask helper.
package gb_cart_pkg;

    localparam int unsigned ROM_AW_DEF = 21;
    localparam int unsigned RAM_AW_DEF = 15;
    localparam int unsigned ROM_BANK_W = 7;
    localparam int unsigned BANK1_W    = 5;
    localparam int unsigned BANK2_W    = 2;
    localparam int unsigned RAM_ADDR_W = 15;

    // Header byte 0x149 encodings
    localparam logic [1:0] RAM_SIZE_NONE = 2'd0;
    localparam logic [1:0] RAM_SIZE_2K   = 2'd1;
    localparam logic [1:0] RAM_SIZE_8K   = 2'd2;
    localparam logic [1:0] RAM_SIZE_32K  = 2'd3;

    // cart_addr[15:13] value of the external RAM window (0xA000-0xBFFF)
    localparam logic [2:0] REGION_RAM = 3'b101;

    // Control-space register select, cart_addr[14:13]
    localparam logic [1:0] REG_RAM_EN = 2'd0;
    localparam logic [1:0] REG_BANK1  = 2'd1;
    localparam logic [1:0] REG_BANK2  = 2'd2;
    localparam logic [1:0] REG_MODE   = 2'd3;

    // Low nibble that unlocks cart RAM
    localparam logic [3:0] RAM_EN_KEY = 4'hA;

    // Bank mask for a ROM of (2 << rom_size) banks; out-of-range sizes saturate to all ones.
    function automatic logic [ROM_BANK_W-1:0] rom_mask(input logic [2:0] rom_size);
        logic [7:0] banks;
        banks = 8'(8'd2 << rom_size);
        return ROM_BANK_W'(banks - 8'd1);
    endfunction

endpackage

// File: rtl/cart_mbc1.sv
// MBC1 cartridge mapper.
// Decodes CPU writes to 0x0000-0x7FFF into bank/mode/RAM-enable registers and
// translates CPU addresses into physical ROM and cart-RAM addresses.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   mbc_en                1 = MBC1 cart, 0 = plain ROM cart
//   rom_size, ram_size    cartridge header size codes
//   cart_addr/rd/wr/di/do CPU-side cartridge bus (cart_do is combinational)
//   rom_addr, rom_rd, rom_q         physical ROM interface
//   ram_addr, ram_wr, ram_di, ram_q physical cart-RAM interface
//   ram_dirty, dirty_clr            battery-save dirty flag and its clear
module cart_mbc1
    import gb_cart_pkg::*;
#(
    parameter int unsigned ROM_AW = ROM_AW_DEF,
    parameter int unsigned RAM_AW = RAM_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mbc_en,
    input  logic [2:0]        rom_size,
    input  logic [1:0]        ram_size,
    input  logic [15:0]       cart_addr,
    input  logic              cart_rd,
    input  logic              cart_wr,
    input  logic [7:0]        cart_di,
    output logic [7:0]        cart_do,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [7:0]        rom_q,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_di,
    input  logic [7:0]        ram_q,
    output logic              ram_dirty,
    input  logic              dirty_clr
);

    logic                  ram_en;
    logic [BANK1_W-1:0]    bank1;
    logic [BANK2_W-1:0]    bank2;
    logic                  mode;
    logic                  wr_d;

    logic                  wr_stb;
    logic                  in_rom;
    logic                  in_ram_win;
    logic                  ram_ok;
    logic                  reg_wr;
    logic [ROM_BANK_W-1:0] rom_bank;
    logic [20:0]           rom_addr_full;
    logic [BANK2_W-1:0]    ram_bank;
    logic [RAM_ADDR_W-1:0] ram_mask;
    logic [RAM_ADDR_W-1:0] ram_addr_full;

    // Write-strobe edge detect, region decode, address translation and read mux
    always_comb begin
        wr_stb        = cart_wr & ~wr_d & ~reset;
        in_rom        = ~cart_addr[15];
        in_ram_win    = (cart_addr[15:13] == REGION_RAM);
        ram_ok        = mbc_en & ram_en & (ram_size != RAM_SIZE_NONE);
        reg_wr        = wr_stb & mbc_en & in_rom;

        rom_bank      = '0;
        if (cart_addr[14]) begin
            rom_bank = {bank2, bank1};
        end else if (mode) begin
            rom_bank = {bank2, BANK1_W'(0)};
        end

        if (mbc_en) begin
            rom_addr_full = {rom_bank & rom_mask(rom_size), cart_addr[13:0]};
        end else begin
            rom_addr_full = {6'b0, cart_addr[14:0]};
        end

        // Upper RAM bank bits only exist on 32 KB carts in mode 1
        ram_bank      = (mode && (ram_size == RAM_SIZE_32K)) ? bank2 : BANK2_W'(0);
        case (ram_size)
            RAM_SIZE_2K:  ram_mask = 15'h07FF;
            RAM_SIZE_8K:  ram_mask = 15'h1FFF;
            RAM_SIZE_32K: ram_mask = 15'h7FFF;
            default:      ram_mask = 15'h0000;
        endcase
        ram_addr_full = {ram_bank, cart_addr[12:0]} & ram_mask;

        cart_do       = 8'hFF;
        if (in_rom) begin
            cart_do = rom_q;
        end else if (in_ram_win && ram_ok) begin
            cart_do = ram_q;
        end

        rom_addr      = ROM_AW'(rom_addr_full);
        rom_rd        = cart_rd & in_rom;
        ram_addr      = RAM_AW'(ram_addr_full);
        ram_wr        = wr_stb & in_ram_win & ram_ok;
        ram_di        = cart_di;
    end

    // Bank registers, write-edge history and dirty flag
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_en    <= 1'b0;
            bank1     <= BANK1_W'(1);
            bank2     <= '0;
            mode      <= 1'b0;
            wr_d      <= 1'b0;
            ram_dirty <= 1'b0;
        end else begin
            wr_d <= cart_wr;
            if (reg_wr) begin
                case (cart_addr[14:13])
                    REG_RAM_EN: ram_en <= (cart_di[3:0] == RAM_EN_KEY);
                    // Bank 0 is unreachable in the upper window; it aliases to 1
                    REG_BANK1:  bank1  <= (cart_di[4:0] == 5'd0) ? BANK1_W'(1) : cart_di[4:0];
                    REG_BANK2:  bank2  <= cart_di[1:0];
                    REG_MODE:   mode   <= cart_di[0];
                    default:    ;
                endcase
            end
            // A write landing together with a clear keeps the flag set
            if (ram_wr) begin
                ram_dirty <= 1'b1;
            end else if (dirty_clr) begin
                ram_dirty <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cart_mbc1.sv
// Directed vector bench for cart_mbc1: a table of read/write records followed
// by hand-written sequences for dirty-flag and reset-during-write cases.
module tb_cart_mbc1;

    logic        clk;
    logic        reset;
    logic        mbc_en;
    logic [2:0]  rom_size;
    logic [1:0]  ram_size;
    logic [15:0] cart_addr;
    logic        cart_rd;
    logic        cart_wr;
    logic [7:0]  cart_di;
    logic [7:0]  cart_do;
    logic [20:0] rom_addr;
    logic        rom_rd;
    logic [7:0]  rom_q;
    logic [14:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_di;
    logic [7:0]  ram_q;
    logic        ram_dirty;
    logic        dirty_clr;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [7:0] ROM_BYTE = 8'hA5;
    localparam logic [7:0] RAM_BYTE = 8'h3C;

    cart_mbc1 dut (
        .clk       (clk),
        .reset     (reset),
        .mbc_en    (mbc_en),
        .rom_size  (rom_size),
        .ram_size  (ram_size),
        .cart_addr (cart_addr),
        .cart_rd   (cart_rd),
        .cart_wr   (cart_wr),
        .cart_di   (cart_di),
        .cart_do   (cart_do),
        .rom_addr  (rom_addr),
        .rom_rd    (rom_rd),
        .rom_q     (rom_q),
        .ram_addr  (ram_addr),
        .ram_wr    (ram_wr),
        .ram_di    (ram_di),
        .ram_q     (ram_q),
        .ram_dirty (ram_dirty),
        .dirty_clr (dirty_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        is_wr;
        logic [15:0] addr;
        logic [7:0]  di;
        int          hold;
        logic [2:0]  rs;
        logic [1:0]  ras;
        logic        mbc;
        logic        chk_rom;
        logic [20:0] exp_rom;
        logic        chk_ram;
        logic [14:0] exp_ram;
        logic [7:0]  exp_do;
        logic        exp_rd;
        int          exp_pulses;
        logic        exp_dirty;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t rv(logic [15:0] a, logic [2:0] rs, logic [1:0] ras, logic mbc,
                                logic chk_rom, logic [20:0] er, logic chk_ram, logic [14:0] em,
                                logic [7:0] ed, logic erd, logic edirty);
        vec_t v;
        v = '{is_wr: 1'b0, addr: a, di: 8'h00, hold: 0, rs: rs, ras: ras, mbc: mbc,
              chk_rom: chk_rom, exp_rom: er, chk_ram: chk_ram, exp_ram: em, exp_do: ed,
              exp_rd: erd, exp_pulses: 0, exp_dirty: edirty};
        return v;
    endfunction

    function automatic vec_t wv(logic [15:0] a, logic [7:0] d, int hold, logic [1:0] ras,
                                logic mbc, int ep, logic chk_ram, logic [14:0] em, logic edirty);
        vec_t v;
        v = '{is_wr: 1'b1, addr: a, di: d, hold: hold, rs: 3'd6, ras: ras, mbc: mbc,
              chk_rom: 1'b0, exp_rom: '0, chk_ram: chk_ram, exp_ram: em, exp_do: 8'h00,
              exp_rd: 1'b0, exp_pulses: ep, exp_dirty: edirty};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Hold cart_wr for 'hold' cycles, counting ram_wr pulses; then release and let wr_d settle.
    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int hold,
                            output int pulses, output logic [14:0] ra);
        cart_addr = a;
        cart_di   = d;
        cart_rd   = 1'b0;
        cart_wr   = 1'b1;
        pulses    = 0;
        ra        = '0;
        for (int c = 0; c < hold; c++) begin
            #1;
            if (ram_wr) begin
                pulses++;
                ra = ram_addr;
            end
            tick();
        end
        cart_wr = 1'b0;
        tick();
    endtask

    initial begin
        int          pulses;
        logic [14:0] ra;
        bit          ok;

        reset     = 1'b1;
        mbc_en    = 1'b1;
        rom_size  = 3'd6;
        ram_size  = 2'd2;
        cart_addr = 16'h4000;
        cart_rd   = 1'b1;
        cart_wr   = 1'b0;
        cart_di   = 8'h00;
        rom_q     = ROM_BYTE;
        ram_q     = RAM_BYTE;
        dirty_clr = 1'b0;
        tick();
        chk("reset_rom_addr", 32'(rom_addr), 32'h04000);
        chk("reset_ram_wr", 32'(ram_wr), 32'h0);
        chk("reset_dirty", 32'(ram_dirty), 32'h0);
        tick();
        reset = 1'b0;
        tick();

        //      addr      rs    ras   mbc  chk  rom        chk  ram       do     rd   dirty
        vq.push_back(rv(16'h4000, 3'd6, 2'd2, 1'b1, 1'b1, 21'h04000, 1'b0, 15'h0, ROM_BYTE, 1'b1, 1'b0));
        vq.push_back(rv(16'h0123, 3'd6, 2'd2, 1'b1, 1'b1, 21'h00123, 1'b0, 15'h0, ROM_BYTE, 1'b1, 1'b0));
        vq.push_back(wv(16'h2000, 8'h00, 1, 2'd2, 1'b1, 0, 1'b0, 15'h0, 1'b0));
        vq.push_back(rv(16'h4000, 3'd6, 2'd2, 1'b1, 1'b1, 21'h04000, 1'b0, 15'h0, ROM_BYTE, 1'b1, 1'b0));
        vq.push_back(wv(16'h2000, 8'h1F, 1, 2'd2, 1'b1, 0, 1'b0, 15'h0, 1'b0));
        vq.push_back(rv(16'h7FFF, 3'd6, 2'd2, 1'b1, 1'b1, 21'h7FFFF, 1'b0, 15'h0, ROM_BYTE, 1'b1, 1'b0));
        vq.push_back(rv(16'h7FFF, 3'd3, 2'd2, 1'b1, 1'b1, 21'h3FFFF, 1'b0, 15'h0, ROM_BYTE, 1'b1, 1'b0));
        vq.push_back(wv(16'h2000, 8'h20, 1, 2'd2, 1'b1, 0, 1'b0, 15'h0, 1'b0));
        vq.push_back(rv(16'h4000, 3'd6, 2'd2, 1'b1, 1'b1, 21'h04000, 1'b0, 15'h0, ROM_BYTE, 1'b1, 1'b0));
        vq.push_back(wv(16'h4000, 8'h02, 1, 2'd2, 1'b1, 0, 1'b0, 15'h0, 1'b0));
        vq.push_back(rv(16'h4000, 3'd6, 2'd2, 1'b1, 1'b1, 21'h104000, 1'b0, 15'h0, ROM_BYTE, 1'b1, 1'b0));
        vq.push_back(rv(16'h0000, 3'd6, 2'd2, 1'b1, 1'b1, 21'h00000, 1'b0, 15'h0, ROM_BYTE, 1'b1, 1'b0));
        vq.push_back(wv(16'h2000, 8'h05, 1, 2'd2, 1'b1, 0, 1'b0, 15'h0, 1'b0));
        vq.push_back(rv(16'h4000, 3'd4, 2'd2, 1'b1, 1'b1, 21'h14000, 1'b0, 15'h0, ROM_BYTE, 1'b1, 1'b0));
        vq.push_back(rv(16'h4000, 3'd6, 2'd2, 1'b1, 1'b1, 21'h114000, 1'b0, 15'h0, ROM_BYTE, 1'b1, 1'b0));
        vq.push_back(wv(16'h6000, 8'h01, 1, 2'd2, 1'b1, 0, 1'b0, 15'h0, 1'b0));
        vq.push_back(rv(16'h0000, 3'd6, 2'd2, 1'b1, 1'b1, 21'h100000, 1'b0, 15'h0, ROM_BYTE, 1'b1, 1'b0));
        vq.push_back(rv(16'h0000, 3'd4, 2'd2, 1'b1, 1'b1, 21'h00000, 1'b0, 15'h0, ROM_BYTE, 1'b1, 1'b0));
        vq.push_back(rv(16'h8000, 3'd6, 2'd2, 1'b1, 1'b0, 21'h0, 1'b0, 15'h0, 8'hFF, 1'b0, 1'b0));
        vq.push_back(rv(16'hA000, 3'd6, 2'd2, 1'b1, 1'b0, 21'h0, 1'b0, 15'h0, 8'hFF, 1'b0, 1'b0));
        vq.push_back(wv(16'h0000, 8'h0A, 4, 2'd2, 1'b1, 0, 1'b0, 15'h0, 1'b0));
        vq.push_back(rv(16'hA000, 3'd6, 2'd2, 1'b1, 1'b0, 21'h0, 1'b1, 15'h0000, RAM_BYTE, 1'b0, 1'b0));
        vq.push_back(wv(16'hA123, 8'h55, 4, 2'd2, 1'b1, 1, 1'b1, 15'h0123, 1'b1));
        vq.push_back(rv(16'hA010, 3'd6, 2'd3, 1'b1, 1'b0, 21'h0, 1'b1, 15'h4010, RAM_BYTE, 1'b0, 1'b1));
        vq.push_back(rv(16'hA010, 3'd6, 2'd1, 1'b1, 1'b0, 21'h0, 1'b1, 15'h0010, RAM_BYTE, 1'b0, 1'b1));
        vq.push_back(rv(16'hBFFF, 3'd6, 2'd2, 1'b1, 1'b0, 21'h0, 1'b1, 15'h1FFF, RAM_BYTE, 1'b0, 1'b1));
        vq.push_back(rv(16'hA000, 3'd6, 2'd0, 1'b1, 1'b0, 21'h0, 1'b0, 15'h0, 8'hFF, 1'b0, 1'b1));
        vq.push_back(wv(16'hA000, 8'h66, 2, 2'd0, 1'b1, 0, 1'b0, 15'h0, 1'b1));
        vq.push_back(rv(16'hC000, 3'd6, 2'd2, 1'b1, 1'b0, 21'h0, 1'b0, 15'h0, 8'hFF, 1'b0, 1'b1));
        vq.push_back(rv(16'h4123, 3'd6, 2'd2, 1'b0, 1'b1, 21'h04123, 1'b0, 15'h0, ROM_BYTE, 1'b1, 1'b1));
        vq.push_back(rv(16'h0123, 3'd6, 2'd2, 1'b0, 1'b1, 21'h00123, 1'b0, 15'h0, ROM_BYTE, 1'b1, 1'b1));
        vq.push_back(rv(16'hA000, 3'd6, 2'd2, 1'b0, 1'b0, 21'h0, 1'b0, 15'h0, 8'hFF, 1'b0, 1'b1));
        vq.push_back(wv(16'hA000, 8'h77, 2, 2'd2, 1'b0, 0, 1'b0, 15'h0, 1'b1));
        vq.push_back(wv(16'h2000, 8'h07, 2, 2'd2, 1'b0, 0, 1'b0, 15'h0, 1'b1));
        vq.push_back(rv(16'h4000, 3'd6, 2'd2, 1'b1, 1'b1, 21'h114000, 1'b0, 15'h0, ROM_BYTE, 1'b1, 1'b1));
        vq.push_back(wv(16'h0000, 8'h00, 1, 2'd2, 1'b1, 0, 1'b0, 15'h0, 1'b1));
        vq.push_back(rv(16'hA000, 3'd6, 2'd2, 1'b1, 1'b0, 21'h0, 1'b0, 15'h0, 8'hFF, 1'b0, 1'b1));
        vq.push_back(wv(16'hA000, 8'h11, 2, 2'd2, 1'b1, 0, 1'b0, 15'h0, 1'b1));

        foreach (vq[i]) begin
            rom_size = vq[i].rs;
            ram_size = vq[i].ras;
            mbc_en   = vq[i].mbc;
            n_vec++;
            if (vq[i].is_wr) begin
                do_write(vq[i].addr, vq[i].di, vq[i].hold, pulses, ra);
                ok = (pulses == vq[i].exp_pulses) && (ram_dirty == vq[i].exp_dirty) &&
                     (!vq[i].chk_ram || ra == vq[i].exp_ram);
                if (!ok) begin
                    n_err++;
                    $display("FAIL vec%0d write 0x%04h: pulses %0d ram_addr 0x%0h dirty %0b, expected pulses %0d ram_addr 0x%0h dirty %0b",
                             i, vq[i].addr, pulses, ra, ram_dirty,
                             vq[i].exp_pulses, vq[i].exp_ram, vq[i].exp_dirty);
                end
            end else begin
                cart_addr = vq[i].addr;
                cart_rd   = 1'b1;
                #1;
                ok = (cart_do == vq[i].exp_do) && (rom_rd == vq[i].exp_rd) && (ram_wr == 1'b0) &&
                     (ram_dirty == vq[i].exp_dirty) &&
                     (!vq[i].chk_rom || rom_addr == vq[i].exp_rom) &&
                     (!vq[i].chk_ram || ram_addr == vq[i].exp_ram);
                if (!ok) begin
                    n_err++;
                    $display("FAIL vec%0d read 0x%04h: do 0x%02h rd %0b rom 0x%0h ram 0x%0h dirty %0b, expected do 0x%02h rd %0b rom 0x%0h ram 0x%0h dirty %0b",
                             i, vq[i].addr, cart_do, rom_rd, rom_addr, ram_addr, ram_dirty,
                             vq[i].exp_do, vq[i].exp_rd, vq[i].exp_rom, vq[i].exp_ram, vq[i].exp_dirty);
                end
                tick();
            end
        end

        // dirty_clr alone clears the flag on the next cycle
        mbc_en   = 1'b1;
        ram_size = 2'd2;
        do_write(16'h0000, 8'h0A, 1, pulses, ra);
        dirty_clr = 1'b1;
        tick();
        dirty_clr = 1'b0;
        chk("dirty_clr_alone", 32'(ram_dirty), 32'h0);

        // RAM write and dirty_clr in the same cycle: set wins
        cart_addr = 16'hA005;
        cart_di   = 8'h42;
        cart_wr   = 1'b1;
        dirty_clr = 1'b1;
        #1;
        chk("collide_ram_wr", 32'(ram_wr), 32'h1);
        tick();
        dirty_clr = 1'b0;
        cart_wr   = 1'b0;
        chk("collide_dirty", 32'(ram_dirty), 32'h1);
        tick();
        dirty_clr = 1'b1;
        tick();
        dirty_clr = 1'b0;
        chk("dirty_clr_after", 32'(ram_dirty), 32'h0);

        // Reset asserted together with a RAM write: no write pulse, state returns to reset values
        cart_addr = 16'hA050;
        cart_wr   = 1'b1;
        reset     = 1'b1;
        #1;
        chk("ram_wr_in_reset", 32'(ram_wr), 32'h0);
        tick();
        chk("ram_wr_in_reset2", 32'(ram_wr), 32'h0);
        cart_wr = 1'b0;
        reset   = 1'b0;
        tick();
        cart_addr = 16'h4000;
        #1;
        chk("post_reset_rom", 32'(rom_addr), 32'h04000);
        chk("post_reset_dirty", 32'(ram_dirty), 32'h0);
        cart_addr = 16'h0000;
        #1;
        chk("post_reset_mode", 32'(rom_addr), 32'h00000);

        // Reset mid-write: after release a still-high cart_wr strobes once more
        tick();
        cart_addr = 16'h2000;
        cart_di   = 8'h03;
        cart_wr   = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        cart_wr   = 1'b0;
        cart_addr = 16'h4000;
        #1;
        chk("reset_midwrite_bank", 32'(rom_addr), 32'h0C000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cart_mbc1.md
Name: cart_mbc1

Overview:
- Cartridge mapper sitting directly downstream of the gb core's cartridge interface (cart_addr/cart_rd/cart_wr/cart_di/cart_do).
- Decodes CPU writes to the 0x0000-0x7FFF control space into MBC1 bank registers.
- Translates 16-bit CPU addresses into physical ROM (up to 2 MB) and cart-RAM (up to 32 KB) addresses.
- Returns read data to the core and flags battery RAM as dirty for save logic.

Parameters:
- ROM_AW, 21, physical ROM address width (2 MB).
- RAM_AW, 15, physical cart-RAM address width (32 KB).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- mbc_en  input  1  1 = MBC1 cart; 0 = ROM-only cart (no banking, no RAM).
- rom_size  input  3  header byte 0x148 (0..6); ROM banks = 2 << rom_size.
- ram_size  input  2  header byte 0x149: 0 none, 1 2 KB, 2 8 KB, 3 32 KB.
- cart_addr  input  16  CPU address from core.
- cart_rd  input  1  core read strobe (level).
- cart_wr  input  1  core write strobe (level, held several clocks per CPU write).
- cart_di  input  8  write data from core.
- cart_do  output  8  read data to core.
- rom_addr  output  ROM_AW  physical ROM address.
- rom_rd  output  1  ROM read enable.
- rom_q  input  8  ROM data (same-cycle valid as presented to core).
- ram_addr  output  RAM_AW  physical cart-RAM address.
- ram_wr  output  1  one-cycle cart-RAM write pulse.
- ram_di  output  8  cart-RAM write data (= cart_di).
- ram_q  input  8  cart-RAM read data.
- ram_dirty  output  1  set on any accepted RAM write.
- dirty_clr  input  1  clears ram_dirty (save complete).

Behaviour:
- Write edge: wr_d registers cart_wr; wr_stb = cart_wr & ~wr_d. Registers and RAM commit only on wr_stb. A held cart_wr produces exactly one commit.
- Reset values: ram_en=0, bank1=5'd1, bank2=2'd0, mode=0, wr_d=0, ram_dirty=0.
- Outputs during/after reset: ram_wr=0; rom_addr reflects reset bank values.
- Register writes (mbc_en=1, wr_stb, cart_addr[15]=0), decoded on cart_addr[14:13]:
  - 00: ram_en <= (cart_di[3:0]==4'hA).
  - 01: bank1 <= cart_di[4:0]; 0 is stored as 1 (so writing 0x00 or 0x20 selects 1/0x21).
  - 10: bank2 <= cart_di[1:0].
  - 11: mode <= cart_di[0].
- Register updates take effect the cycle after wr_stb.
- ROM mapping (cart_addr[15]=0), rom_mask = (2<<rom_size)-1 (7 bits):
  - 0x0000-0x3FFF: bank = mode ? {bank2,5'b0} : 0.
  - 0x4000-0x7FFF: bank = {bank2,bank1}.
  - rom_addr = {bank & rom_mask, cart_addr[13:0]}.
  - rom_rd = cart_rd & ~cart_addr[15].
- mbc_en=0: rom_addr = {6'b0,cart_addr[14:0]}; register writes ignored; RAM is treated as absent.
- RAM window 0xA000-0xBFFF: ram_ok = mbc_en & ram_en & (ram_size!=0).
  - ram bank = (mode & ram_size==3) ? bank2 : 0.
  - ram_addr = {bank,cart_addr[12:0]}, masked to 0x7FF for size 1 and 0x1FFF for size 2.
- RAM write: ram_wr = wr_stb & RAM window & ram_ok. Writes when ~ram_ok are dropped silently.
- cart_do is a combinational mux on the current cart_addr:
  - ROM range -> rom_q.
  - RAM window: ram_ok ? ram_q : 8'hFF.
  - Anything else -> 8'hFF.
- ram_dirty: set on ram_wr, cleared on dirty_clr. When both occur in the same cycle, set wins.
- Reset asserted mid-write: wr_d clears; if cart_wr is still high after reset release, one further strobe occurs (accepted behaviour).
- A rom_size beyond the cart's real size wraps via rom_mask: bank 0x45 on a 32-bank ROM maps to bank 0x05.

Decomposition:
- Package gb_cart_pkg holds:
  - RAM_SIZE_* and region-decode constants.
  - A rom_mask function.
- No sub-module. A later MBC3/MBC5 would share the package and the edge-detect idiom.

Test Plan:
- Reset, then read 0x4000 with rom_size=6 -> rom_addr=0x04000 (bank 1), cart_do=rom_q.
- Write 0x00 to 0x2000 -> bank1=1. Then write 0x1F -> read 0x7FFF gives rom_addr=0x7FFFF. Set rom_size=3 -> rom_addr=0x3FFFF (masked to bank 0x0F).
- Hold cart_wr for 4 clocks writing 0x0A to 0x0000, then 0x55 to 0xA123 with ram_size=2 -> exactly one ram_wr pulse, ram_addr=0x0123, ram_dirty=1.
- RAM disabled (write 0x00 to 0x0000), read 0xA000 -> cart_do=0xFF; write 0xA000 -> no ram_wr, ram_dirty unchanged.
- mode=1, bank2=2, ram_size=3 -> read 0x0000 gives rom_addr=0x100000; RAM 0xA010 gives ram_addr=0x4010.
- dirty_clr and ram_wr in the same cycle -> ram_dirty stays 1. dirty_clr alone -> ram_dirty=0 next cycle.
